seq_run_ctrl: RTL and testbench
===============================

SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

Interface
REQ-001 SHALL have: clk  input  1  clock; all logic on posedge clk.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  run request; accepted only in IDLE.
REQ-004 SHALL have: stop  input  1  abort; highest priority after rst.
REQ-005 SHALL have: pause  input  1  level; freezes the sequence while in RUN.
REQ-006 SHALL have: dir  input  1  0 = forward 0,1,3,7,6,4; 1 = reverse 0,4,6,7,3,1; sampled only when start is accepted.
REQ-007 SHALL have: loops  input  4  full cycles to run; 0 = run continuously; sampled only when start is accepted.
REQ-008 SHALL have: out  output  3  current sequence code.
REQ-009 SHALL have: busy  output  1  high in RUN and PAUSE.
REQ-010 SHALL have: done  output  1  one-cycle pulse when the programmed loop count completes.
REQ-011 SHALL have: loop_cnt  output  4  loops completed since the last accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1 and stop=0: latch dir and loops, enter RUN next cycle, keep out=0, clear loop_cnt to 0.
REQ-014 SHALL, in RUN with pause=0: advance out one step per cycle in the latched direction.
REQ-015 SHALL ignore start in RUN, PAUSE and DONE.
REQ-016 SHALL count a loop when out steps from the last code (4 forward, 1 reverse) back to 0; loop_cnt increments in that same cycle.
REQ-017 SHALL, when loops≠0 and the increment makes loop_cnt equal loops, enter DONE with out=0; done=1 for exactly that DONE cycle; next state IDLE.
REQ-018 SHALL, when loops=0, never assert done; loop_cnt wraps 15→0.
REQ-019 SHALL, with pause=1 in RUN: enter PAUSE next cycle with out held; PAUSE returns to RUN the cycle after pause=0; resumes from the held code, no step skipped or repeated.
REQ-020 SHALL apply priority stop > pause > advance; stop=1 in any state → IDLE next cycle, out=0, done=0, loop_cnt held.
REQ-021 SHALL, for start=1 and stop=1 in the same IDLE cycle, remain in IDLE.
REQ-022 SHALL, with pause=1 in the same cycle that completes the final loop, still finish: DONE has priority over PAUSE.
REQ-023 SHALL keep out within {0,1,3,7,6,4}; any other internal code → out=0 and state IDLE next cycle.

Reset
REQ-024 SHALL, with rst=1 at posedge: state IDLE, out=0, busy=0, done=0, loop_cnt=0.
REQ-025 SHALL treat rst mid-RUN or mid-PAUSE identically; rst dominates stop and start.

Verification
REQ-026 SHALL cover forward run: start, dir=0, loops=2 → out 0,1,3,7,6,4,0,1,3,7,6,4,0; loop_cnt 1 then 2; done pulses once; busy drops with DONE.
REQ-027 SHALL cover reverse run: dir=1, loops=1 → out 0,4,6,7,3,1,0; done=1 for one cycle; loop_cnt=1.
REQ-028 SHALL cover pause at out=7 for 3 cycles → out holds 7, busy=1; after release, next code is 6.
REQ-029 SHALL cover stop at out=3 in loop 1 → next cycle out=0, busy=0, loop_cnt=0, no done pulse.
REQ-030 SHALL cover loops=0 for 100 cycles → done never 1; loop_cnt wraps 15→0.
REQ-031 SHALL cover rst at out=6 during RUN → next cycle all outputs at reset values; a new start with dir=1 begins at 0 then 4.

Source files
------------

// File: rtl/seq_run_ctrl.sv
// Sequence run controller: steps a 3-bit code through 0,1,3,7,6,4 (or the reverse),
// counting loops, with pause, abort and a one-cycle completion pulse.
module seq_run_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    input  logic [3:0] loops,
    output logic [2:0] out,
    output logic       busy,
    output logic       done,
    output logic [3:0] loop_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    logic       dir_q;
    logic [3:0] loops_q;

    logic       code_ok;
    logic [2:0] next_code;
    logic       at_last;
    logic [3:0] loop_inc;
    logic       finish;

    assign state_dbg = state;

    // Handshake: start is a request sampled only while IDLE; there is no
    // acknowledge other than busy rising on the following cycle.
    always_comb begin
        code_ok   = 1'b0;
        next_code = 3'd0;
        case (out)
            3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4: code_ok = 1'b1;
            default:                            code_ok = 1'b0;
        endcase
        if (!dir_q) begin
            case (out)
                3'd0:    next_code = 3'd1;
                3'd1:    next_code = 3'd3;
                3'd3:    next_code = 3'd7;
                3'd7:    next_code = 3'd6;
                3'd6:    next_code = 3'd4;
                default: next_code = 3'd0;
            endcase
        end else begin
            case (out)
                3'd0:    next_code = 3'd4;
                3'd4:    next_code = 3'd6;
                3'd6:    next_code = 3'd7;
                3'd7:    next_code = 3'd3;
                3'd3:    next_code = 3'd1;
                default: next_code = 3'd0;
            endcase
        end
        at_last  = (out == (dir_q ? 3'd1 : 3'd4));
        loop_inc = loop_cnt + 4'd1;
        // Completing the final programmed loop wins over a simultaneous pause.
        finish   = at_last && (loops_q != 4'd0) && (loop_inc == loops_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out      <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            loop_cnt <= 4'd0;
            dir_q    <= 1'b0;
            loops_q  <= 4'd0;
        end else if (stop || !code_ok) begin
            state <= IDLE;
            out   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        out      <= 3'd0;
                        loop_cnt <= 4'd0;
                        dir_q    <= dir;
                        loops_q  <= loops;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state    <= DONE;
                        out      <= 3'd0;
                        loop_cnt <= loop_inc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else if (pause) begin
                        state <= PAUSE;
                    end else begin
                        out <= next_code;
                        if (at_last) loop_cnt <= loop_inc;
                    end
                end
                PAUSE: begin
                    if (!pause) state <= RUN;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    out   <= 3'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl: directed scenarios with literal traces plus randomized
// stimulus, all checked every cycle against an index-based sequence model.
module tb_seq_run_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, dir;
    logic [3:0] loops;
    logic [2:0] out;
    logic       busy, done;
    logic [3:0] loop_cnt;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    seq_run_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .loops(loops), .out(out), .busy(busy), .done(done),
        .loop_cnt(loop_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: position index into the code table of the chosen direction
    logic [2:0] seq_tab [2][6];
    logic       m_active, m_paused, m_done, m_dir;
    int         m_idx;
    logic [3:0] m_cnt, m_loops;

    initial begin
        seq_tab[0][0] = 3'd0; seq_tab[0][1] = 3'd1; seq_tab[0][2] = 3'd3;
        seq_tab[0][3] = 3'd7; seq_tab[0][4] = 3'd6; seq_tab[0][5] = 3'd4;
        seq_tab[1][0] = 3'd0; seq_tab[1][1] = 3'd4; seq_tab[1][2] = 3'd6;
        seq_tab[1][3] = 3'd7; seq_tab[1][4] = 3'd3; seq_tab[1][5] = 3'd1;
        m_active = 0; m_paused = 0; m_done = 0; m_dir = 0;
        m_idx = 0; m_cnt = 0; m_loops = 0;
    end

    always @(posedge clk) begin
        logic [2:0] e_out;
        if (rst) begin
            m_active = 0; m_paused = 0; m_done = 0; m_idx = 0; m_cnt = 0;
        end else if (stop) begin
            m_active = 0; m_paused = 0; m_done = 0; m_idx = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_dir = dir; m_loops = loops; m_cnt = 0; m_idx = 0;
            end
        end else if (m_paused) begin
            if (!pause) m_paused = 0;
        end else if (m_idx == 5 && m_loops != 0 && 4'(m_cnt + 1) == m_loops) begin
            m_cnt = m_cnt + 1; m_active = 0; m_done = 1; m_idx = 0;
        end else if (pause) begin
            m_paused = 1;
        end else begin
            m_idx = (m_idx + 1) % 6;
            if (m_idx == 0) m_cnt = m_cnt + 1;
        end
        #1;
        e_out = m_active ? seq_tab[m_dir][m_idx] : 3'd0;
        check("model", {7'd0, out, busy, done, loop_cnt}, {7'd0, e_out, m_active, m_done, m_cnt});
    end

    // driver tasks
    task automatic clear_in();
        rst = 0; start = 0; stop = 0; pause = 0; dir = 0; loops = 0;
    endtask

    task automatic wait_out(input logic [2:0] code, input string name);
        for (int i = 0; i < 40; i++) begin
            if (out === code) return;
            @(negedge clk);
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: timeout waiting for out=%0d, got %0d", name, code, out);
    endtask

    task automatic launch(input logic d, input logic [3:0] l);
        start = 1; dir = d; loops = l;
        @(negedge clk);
        start = 0; dir = $urandom_range(0, 1); loops = 4'($urandom_range(0, 15));
    endtask

    logic [2:0] fwd_exp [13];
    logic [2:0] rev_exp [7];
    int  done_seen;
    bit  wrap_seen;
    logic [3:0] prev_cnt;

    initial begin
        fwd_exp = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0};
        rev_exp = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd3, 3'd1, 3'd0};
        clear_in();
        rst = 1;
        repeat (3) @(negedge clk);
        check("reset_out", 16'(out), 16'd0);
        check("reset_flags", {14'd0, busy, done}, 16'd0);
        check("reset_cnt", 16'(loop_cnt), 16'd0);
        rst = 0;
        @(negedge clk);

        // forward, two loops
        launch(1'b0, 4'd2);
        for (int i = 0; i < 13; i++) begin
            check("fwd_out", 16'(out), 16'(fwd_exp[i]));
            check("fwd_cnt", 16'(loop_cnt), (i < 6) ? 16'd0 : (i < 12) ? 16'd1 : 16'd2);
            check("fwd_busy_done", {14'd0, busy, done}, (i < 12) ? 16'd2 : 16'd1);
            @(negedge clk);
        end
        check("fwd_after_done", {14'd0, busy, done}, 16'd0);

        // reverse, one loop
        launch(1'b1, 4'd1);
        for (int i = 0; i < 7; i++) begin
            check("rev_out", 16'(out), 16'(rev_exp[i]));
            check("rev_done", 16'(done), (i == 6) ? 16'd1 : 16'd0);
            @(negedge clk);
        end
        check("rev_cnt", 16'(loop_cnt), 16'd1);

        // pause at 7 for three cycles
        launch(1'b0, 4'd0);
        wait_out(3'd7, "pause_wait");
        pause = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_hold", {12'd0, out, busy}, {12'd0, 3'd7, 1'b1});
        end
        pause = 0;
        @(negedge clk);
        check("pause_resume_hold", 16'(out), 16'd7);
        @(negedge clk);
        check("pause_next", 16'(out), 16'd6);
        stop = 1; @(negedge clk); stop = 0;

        // stop at 3 in the first loop
        launch(1'b0, 4'd2);
        wait_out(3'd3, "stop_wait");
        stop = 1;
        @(negedge clk);
        stop = 0;
        check("stop_state", {9'd0, out, busy, done, loop_cnt}, 16'd0);

        // start and stop together stay idle
        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        @(negedge clk);
        check("start_stop_idle", 16'(busy), 16'd0);

        // pause on the completing step: done still wins
        launch(1'b0, 4'd1);
        wait_out(3'd4, "final_wait");
        pause = 1;
        @(negedge clk);
        check("final_vs_pause", {9'd0, out, busy, done, loop_cnt}, {9'd0, 3'd0, 1'b0, 1'b1, 4'd1});
        pause = 0;
        @(negedge clk);

        // continuous run with loop counter wrap
        launch(1'b1, 4'd0);
        done_seen = 0; wrap_seen = 0; prev_cnt = loop_cnt;
        for (int i = 0; i < 110; i++) begin
            if (done) done_seen++;
            if (prev_cnt == 4'd15 && loop_cnt == 4'd0) wrap_seen = 1;
            prev_cnt = loop_cnt;
            @(negedge clk);
        end
        check("cont_no_done", 16'(done_seen), 16'd0);
        check("cont_wrap", 16'(wrap_seen), 16'd1);
        check("cont_busy", 16'(busy), 16'd1);
        stop = 1; @(negedge clk); stop = 0;

        // reset at 6 mid-run, then reverse restart
        launch(1'b0, 4'd3);
        wait_out(3'd6, "rst_wait");
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_mid_run", {9'd0, out, busy, done, loop_cnt}, 16'd0);
        launch(1'b1, 4'd1);
        check("restart_first", 16'(out), 16'd0);
        @(negedge clk);
        check("restart_second", 16'(out), 16'd4);

        // randomized stimulus, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 6) == 0);
            dir   = $urandom_range(0, 1);
            loops = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
            @(negedge clk);
        end
        clear_in();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
